// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - opcode, instruction class, ALU op, state and trap encodings for the sequencer
package core_pkg;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_OPIMM  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   localparam logic [1:0] ALU_ADD    = 2'b00;
   localparam logic [1:0] ALU_BRANCH = 2'b01;
   localparam logic [1:0] ALU_RTYPE  = 2'b10;
   localparam logic [1:0] ALU_ITYPE  = 2'b11;

   localparam logic [1:0] TRAP_NONE    = 2'b00;
   localparam logic [1:0] TRAP_ILLEGAL = 2'b01;
   localparam logic [1:0] TRAP_TIMEOUT = 2'b10;

   typedef enum logic [2:0] {
      CLS_R, CLS_LOAD, CLS_STORE, CLS_OPIMM, CLS_BRANCH
   } instrClassT;

   typedef enum logic [2:0] {
      ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_TRAP
   } seqStateT;

   typedef struct packed {
      logic       legal;
      instrClassT cls;
   } decodeT;

   function automatic decodeT decodeOpcode(logic [6:0] op);
      decodeT d;
      d.legal = 1'b1;
      d.cls   = CLS_R;
      case (op)
         OP_R:      d.cls = CLS_R;
         OP_LOAD:   d.cls = CLS_LOAD;
         OP_STORE:  d.cls = CLS_STORE;
         OP_OPIMM:  d.cls = CLS_OPIMM;
         OP_BRANCH: d.cls = CLS_BRANCH;
         default:   d.legal = 1'b0;
      endcase
      return d;
   endfunction

   function automatic logic [1:0] aluOpFor(instrClassT c);
      case (c)
         CLS_R:      return ALU_RTYPE;
         CLS_OPIMM:  return ALU_ITYPE;
         CLS_BRANCH: return ALU_BRANCH;
         default:    return ALU_ADD;
      endcase
   endfunction

   // Loads and stores use the immediate for address generation.
   function automatic logic aluSrcFor(instrClassT c);
      return (c == CLS_OPIMM) || (c == CLS_LOAD) || (c == CLS_STORE);
   endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// rtl/mem_wait_timer.sv - counts memory wait cycles and flags the one that reaches LIMIT
module mem_wait_timer #(
   parameter int LIMIT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic waiting,
   output logic expired
);

   localparam int W = $clog2(LIMIT + 1);

   logic [W-1:0] waitCount;

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         waitCount <= '0;
      end else if (waiting) begin
         waitCount <= waitCount + 1'b1;
      end
   end

   // Combinational so the LIMIT-th wait cycle itself steers the FSM into TRAP.
   assign expired = waiting && (waitCount == W'(LIMIT - 1));

endmodule

// File: rtl/multicycle_sequencer.sv
// rtl/multicycle_sequencer.sv - FETCH/DECODE/EXEC/MEM/WB sequencer for the RV32 core
// SEQ_MEM_TIMEOUT_EN: bound imem/dmem waits by MEM_TIMEOUT cycles, trapping with cause 10.
module multicycle_sequencer
   import core_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] opcode,
   input  logic       stall,
   input  logic       branch_taken,
   output logic       imem_req,
   input  logic       imem_ready,
   output logic       dmem_req,
   output logic       dmem_we,
   input  logic       dmem_ready,
   output logic       ir_we,
   output logic       pc_we,
   output logic       pc_src,
   output logic [1:0] alu_op,
   output logic       alu_src,
   output logic       reg_we,
   output logic       mem_to_reg,
   output logic       instr_retired,
   output logic [1:0] trap_cause
);

   seqStateT   state, stateNext;
   instrClassT instrClass;
   logic [1:0] trapCause;
   decodeT     dec;
   logic       timeoutHit;
   logic       memWaiting;

   assign dec = decodeOpcode(opcode);

   // Derived from state rather than the request outputs to keep the timer out of a comb loop.
   assign memWaiting = ((state == ST_FETCH) && !stall && !imem_ready) ||
                       ((state == ST_MEM) && !dmem_ready);

`ifdef SEQ_MEM_TIMEOUT_EN
   mem_wait_timer #(
      .LIMIT(MEM_TIMEOUT)
   ) u_mem_wait_timer (
      .clk    (clk),
      .rst    (rst),
      .clear  (stateNext != state),
      .waiting(memWaiting),
      .expired(timeoutHit)
   );
`else
   // Timer compiled out: waits are unbounded.
   assign timeoutHit = 1'b0 && memWaiting && (MEM_TIMEOUT > 0);
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_FETCH;
         instrClass <= CLS_R;
         trapCause  <= TRAP_NONE;
      end else begin
         state <= stateNext;
         if (state == ST_DECODE) begin
            instrClass <= dec.cls;
         end
         if ((state == ST_DECODE) && !dec.legal) begin
            trapCause <= TRAP_ILLEGAL;
         end else if (timeoutHit) begin
            trapCause <= TRAP_TIMEOUT;
         end
      end
   end

   always_comb begin
      stateNext     = state;
      imem_req      = 1'b0;
      dmem_req      = 1'b0;
      dmem_we       = 1'b0;
      ir_we         = 1'b0;
      pc_we         = 1'b0;
      pc_src        = 1'b0;
      alu_op        = ALU_ADD;
      alu_src       = 1'b0;
      reg_we        = 1'b0;
      mem_to_reg    = 1'b0;
      instr_retired = 1'b0;
      trap_cause    = trapCause;

      case (state)
         ST_FETCH: begin
            if (!stall) begin
               imem_req = 1'b1;
               if (imem_ready) begin
                  ir_we     = 1'b1;
                  stateNext = ST_DECODE;
               end else if (timeoutHit) begin
                  stateNext = ST_TRAP;
               end
            end
         end
         ST_DECODE: begin
            stateNext = dec.legal ? ST_EXEC : ST_TRAP;
         end
         ST_EXEC: begin
            alu_op  = aluOpFor(instrClass);
            alu_src = aluSrcFor(instrClass);
            case (instrClass)
               CLS_BRANCH: begin
                  pc_we         = 1'b1;
                  pc_src        = branch_taken;
                  instr_retired = 1'b1;
                  stateNext     = ST_FETCH;
               end
               CLS_LOAD, CLS_STORE: stateNext = ST_MEM;
               default:             stateNext = ST_WB;
            endcase
         end
         ST_MEM: begin
            dmem_req = 1'b1;
            dmem_we  = (instrClass == CLS_STORE);
            alu_op   = aluOpFor(instrClass);
            alu_src  = aluSrcFor(instrClass);
            if (dmem_ready) begin
               if (instrClass == CLS_STORE) begin
                  pc_we         = 1'b1;
                  instr_retired = 1'b1;
                  stateNext     = ST_FETCH;
               end else begin
                  stateNext = ST_WB;
               end
            end else if (timeoutHit) begin
               stateNext = ST_TRAP;
            end
         end
         ST_WB: begin
            reg_we        = 1'b1;
            mem_to_reg    = (instrClass == CLS_LOAD);
            pc_we         = 1'b1;
            instr_retired = 1'b1;
            stateNext     = ST_FETCH;
         end
         ST_TRAP: begin
            stateNext = ST_TRAP;
         end
         default: stateNext = ST_FETCH;
      endcase

      // Reset silences every strobe immediately so an aborted instruction never commits.
      if (rst) begin
         imem_req      = 1'b0;
         dmem_req      = 1'b0;
         dmem_we       = 1'b0;
         ir_we         = 1'b0;
         pc_we         = 1'b0;
         pc_src        = 1'b0;
         alu_op        = ALU_ADD;
         alu_src       = 1'b0;
         reg_we        = 1'b0;
         mem_to_reg    = 1'b0;
         instr_retired = 1'b0;
         trap_cause    = TRAP_NONE;
      end
   end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb/tb_multicycle_sequencer.sv - directed self-checking bench for multicycle_sequencer
module tb_multicycle_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic [6:0] opcode;
   logic       stall;
   logic       branch_taken;
   logic       imem_req;
   logic       imem_ready;
   logic       dmem_req;
   logic       dmem_we;
   logic       dmem_ready;
   logic       ir_we;
   logic       pc_we;
   logic       pc_src;
   logic [1:0] alu_op;
   logic       alu_src;
   logic       reg_we;
   logic       mem_to_reg;
   logic       instr_retired;
   logic [1:0] trap_cause;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   multicycle_sequencer #(
      .MEM_TIMEOUT(16)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .opcode       (opcode),
      .stall        (stall),
      .branch_taken (branch_taken),
      .imem_req     (imem_req),
      .imem_ready   (imem_ready),
      .dmem_req     (dmem_req),
      .dmem_we      (dmem_we),
      .dmem_ready   (dmem_ready),
      .ir_we        (ir_we),
      .pc_we        (pc_we),
      .pc_src       (pc_src),
      .alu_op       (alu_op),
      .alu_src      (alu_src),
      .reg_we       (reg_we),
      .mem_to_reg   (mem_to_reg),
      .instr_retired(instr_retired),
      .trap_cause   (trap_cause)
   );

   // {imem_req,dmem_req,dmem_we,ir_we,pc_we,pc_src,alu_op,alu_src,reg_we,mem_to_reg,instr_retired,trap_cause}
   wire [13:0] outs = {imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_src, alu_op,
                       alu_src, reg_we, mem_to_reg, instr_retired, trap_cause};

   localparam logic [13:0] IDLE        = 14'b0_0_0_0_0_0_00_0_0_0_0_00;
   localparam logic [13:0] F_REQ       = 14'b1_0_0_0_0_0_00_0_0_0_0_00;
   localparam logic [13:0] F_ACK       = 14'b1_0_0_1_0_0_00_0_0_0_0_00;
   localparam logic [13:0] EX_R        = 14'b0_0_0_0_0_0_10_0_0_0_0_00;
   localparam logic [13:0] EX_I        = 14'b0_0_0_0_0_0_11_1_0_0_0_00;
   localparam logic [13:0] EX_MEM      = 14'b0_0_0_0_0_0_00_1_0_0_0_00;
   localparam logic [13:0] WB_ALU      = 14'b0_0_0_0_1_0_00_0_1_0_1_00;
   localparam logic [13:0] WB_LD       = 14'b0_0_0_0_1_0_00_0_1_1_1_00;
   localparam logic [13:0] MEM_LD      = 14'b0_1_0_0_0_0_00_1_0_0_0_00;
   localparam logic [13:0] MEM_ST_WAIT = 14'b0_1_1_0_0_0_00_1_0_0_0_00;
   localparam logic [13:0] MEM_ST_DONE = 14'b0_1_1_0_1_0_00_1_0_0_1_00;
   localparam logic [13:0] BR_T        = 14'b0_0_0_0_1_1_01_0_0_0_1_00;
   localparam logic [13:0] BR_N        = 14'b0_0_0_0_1_0_01_0_0_0_1_00;
   localparam logic [13:0] TRAP_ILL    = 14'b0_0_0_0_0_0_00_0_0_0_0_01;
   localparam logic [13:0] TRAP_TO     = 14'b0_0_0_0_0_0_00_0_0_0_0_10;

   task automatic tick;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset;
      rst          = 1'b1;
      stall        = 1'b0;
      imem_ready   = 1'b0;
      dmem_ready   = 1'b0;
      branch_taken = 1'b0;
      opcode       = 7'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset;
      rst          = 1'b1;
      stall        = 1'b0;
      imem_ready   = 1'b1;
      dmem_ready   = 1'b1;
      branch_taken = 1'b1;
      opcode       = 7'b0110011;
      #1;
      checks++;
      if (outs !== IDLE) begin
         failures++;
         $display("FAIL reset_initial: got %b want %b", outs, IDLE);
      end
      tick();
      checks++;
      if (outs !== IDLE) begin
         failures++;
         $display("FAIL reset_held: got %b want %b", outs, IDLE);
      end
      imem_ready = 1'b0;
      rst = 1'b0;
      #1;
      checks++;
      if (outs !== F_REQ) begin
         failures++;
         $display("FAIL reset_release: got %b want %b", outs, F_REQ);
      end
      tick();
   endtask

   task automatic test_rtype;
      logic [13:0] exp [5];
      exp = '{F_ACK, IDLE, EX_R, WB_ALU, F_ACK};
      do_reset();
      opcode = 7'b0110011;
      imem_ready = 1'b1;
      dmem_ready = 1'b1;
      for (int c = 0; c < 5; c++) begin
         #1;
         checks++;
         if (outs !== exp[c]) begin
            failures++;
            $display("FAIL rtype cycle %0d: got %b want %b", c + 1, outs, exp[c]);
         end
         tick();
      end
   endtask

   task automatic test_opimm;
      logic [13:0] exp [5];
      exp = '{F_ACK, IDLE, EX_I, WB_ALU, F_ACK};
      do_reset();
      opcode = 7'b0010011;
      imem_ready = 1'b1;
      for (int c = 0; c < 5; c++) begin
         #1;
         checks++;
         if (outs !== exp[c]) begin
            failures++;
            $display("FAIL opimm cycle %0d: got %b want %b", c + 1, outs, exp[c]);
         end
         tick();
      end
   endtask

   task automatic test_load_wait;
      logic [13:0] exp [9];
      exp = '{F_ACK, IDLE, EX_MEM, MEM_LD, MEM_LD, MEM_LD, MEM_LD, WB_LD, F_ACK};
      do_reset();
      opcode = 7'b0000011;
      imem_ready = 1'b1;
      for (int c = 0; c < 9; c++) begin
         dmem_ready = (c >= 6);
         #1;
         checks++;
         if (outs !== exp[c]) begin
            failures++;
            $display("FAIL load_wait cycle %0d: got %b want %b", c + 1, outs, exp[c]);
         end
         tick();
      end
   endtask

   task automatic test_store;
      logic [13:0] exp [5];
      exp = '{F_ACK, IDLE, EX_MEM, MEM_ST_DONE, F_ACK};
      do_reset();
      opcode = 7'b0100011;
      imem_ready = 1'b1;
      dmem_ready = 1'b1;
      for (int c = 0; c < 5; c++) begin
         #1;
         checks++;
         if (outs !== exp[c]) begin
            failures++;
            $display("FAIL store cycle %0d: got %b want %b", c + 1, outs, exp[c]);
         end
         tick();
      end
   endtask

   task automatic test_back_to_back;
      logic [13:0] exp [7];
      exp = '{F_ACK, IDLE, BR_T, F_ACK, IDLE, BR_N, F_ACK};
      do_reset();
      opcode = 7'b1100011;
      imem_ready = 1'b1;
      dmem_ready = 1'b1;
      for (int c = 0; c < 7; c++) begin
         branch_taken = (c < 3);
         #1;
         checks++;
         if (outs !== exp[c]) begin
            failures++;
            $display("FAIL branch cycle %0d: got %b want %b", c + 1, outs, exp[c]);
         end
         tick();
      end
      branch_taken = 1'b0;
   endtask

   task automatic test_fetch_stall;
      logic [13:0] exp [7];
      exp = '{IDLE, IDLE, F_REQ, F_REQ, F_ACK, IDLE, EX_R};
      do_reset();
      opcode = 7'b0110011;
      for (int c = 0; c < 7; c++) begin
         stall      = (c < 2) || (c >= 5);
         imem_ready = (c < 2) || (c >= 4);
         #1;
         checks++;
         if (outs !== exp[c]) begin
            failures++;
            $display("FAIL fetch_stall cycle %0d: got %b want %b", c + 1, outs, exp[c]);
         end
         tick();
      end
      stall = 1'b0;
   endtask

   task automatic test_illegal;
      logic [13:0] exp [3];
      exp = '{F_ACK, IDLE, TRAP_ILL};
      do_reset();
      opcode = 7'b1111111;
      imem_ready = 1'b1;
      dmem_ready = 1'b1;
      for (int c = 0; c < 3; c++) begin
         #1;
         checks++;
         if (outs !== exp[c]) begin
            failures++;
            $display("FAIL illegal cycle %0d: got %b want %b", c + 1, outs, exp[c]);
         end
         tick();
      end
      opcode = 7'b0110011;
      for (int c = 0; c < 50; c++) begin
         #1;
         checks++;
         if (outs !== TRAP_ILL) begin
            failures++;
            $display("FAIL trap_hold cycle %0d: got %b want %b", c + 4, outs, TRAP_ILL);
         end
         tick();
      end
      rst = 1'b1;
      #1;
      checks++;
      if (outs !== IDLE) begin
         failures++;
         $display("FAIL trap_reset: got %b want %b", outs, IDLE);
      end
      tick();
      rst = 1'b0;
      imem_ready = 1'b0;
      #1;
      checks++;
      if (outs !== F_REQ) begin
         failures++;
         $display("FAIL trap_exit: got %b want %b", outs, F_REQ);
      end
      tick();
   endtask

   task automatic test_reset_mid_store;
      logic [13:0] exp [5];
      exp = '{F_ACK, IDLE, EX_MEM, MEM_ST_WAIT, MEM_ST_WAIT};
      do_reset();
      opcode = 7'b0100011;
      imem_ready = 1'b1;
      dmem_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         #1;
         checks++;
         if (outs !== exp[c]) begin
            failures++;
            $display("FAIL store_abort cycle %0d: got %b want %b", c + 1, outs, exp[c]);
         end
         tick();
      end
      rst = 1'b1;
      dmem_ready = 1'b1;
      #1;
      checks++;
      if (outs !== IDLE) begin
         failures++;
         $display("FAIL store_abort_rst: got %b want %b", outs, IDLE);
      end
      tick();
      rst = 1'b0;
      imem_ready = 1'b0;
      for (int c = 0; c < 2; c++) begin
         #1;
         checks++;
         if (outs !== F_REQ) begin
            failures++;
            $display("FAIL store_abort_release %0d: got %b want %b", c, outs, F_REQ);
         end
         tick();
      end
   endtask

   task automatic test_mem_timeout;
      logic [13:0] want;
      do_reset();
      opcode = 7'b0000011;
      imem_ready = 1'b1;
      dmem_ready = 1'b0;
      for (int c = 1; c <= 100; c++) begin
         #1;
         if (c == 4 || c == 19 || c == 20 || c == 100) begin
`ifdef SEQ_MEM_TIMEOUT_EN
            want = (c >= 20) ? TRAP_TO : MEM_LD;
`else
            want = MEM_LD;
`endif
            checks++;
            if (outs !== want) begin
               failures++;
               $display("FAIL mem_timeout cycle %0d: got %b want %b", c, outs, want);
            end
         end
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_rtype();
      test_opimm();
      test_load_wait();
      test_store();
      test_back_to_back();
      test_fetch_stall();
      test_illegal();
      test_reset_mid_store();
      test_mem_timeout();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
